// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares one sram-like port between fetch and data requesters,
//            routing returns in order through an owner FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_FULL  = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

    logic [MAX_OUTSTANDING-1:0] owner_mem;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       lock_valid;
    logic                       lock_owner;
    logic [SW-1:0]              starve_cnt;

    logic sel;
    logic full;
    logic hs;
    logic pop;
    logic head;

    // sel: 1 = data requester, 0 = fetch requester
    always_comb begin
        sel = 1'b0;
        if (lock_valid)
            sel = lock_owner;
        else if (inst_req && (starve_cnt == C_LIMIT))
            sel = 1'b0;
        else if (data_req)
            sel = 1'b1;
    end

    assign full = (count == C_FULL);
    assign hs   = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & (count != '0);
    assign head = owner_mem[rd_ptr];

    assign mem_req    = (sel ? data_req : inst_req) & ~full;
    assign mem_wr     = sel ? data_wr    : inst_wr;
    assign mem_size   = sel ? data_size  : inst_size;
    assign mem_wstrb  = sel ? data_wstrb : inst_wstrb;
    assign mem_addr   = sel ? data_addr  : inst_addr;
    assign mem_wdata  = sel ? data_wdata : inst_wdata;

    assign inst_addr_ok = hs & ~sel;
    assign data_addr_ok = hs &  sel;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop &  head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            owner_mem  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            starve_cnt <= '0;
            arb_err    <= 1'b0;
        end else begin
            if (hs) begin
                owner_mem[wr_ptr] <= sel;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({hs, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Hold the choice while a request waits for addr_ok
            if (hs)
                lock_valid <= 1'b0;
            else if (mem_req && !lock_valid) begin
                lock_valid <= 1'b1;
                lock_owner <= sel;
            end

            if (!inst_req || (hs && !sel))
                starve_cnt <= '0;
            else if (hs && sel && (starve_cnt != C_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);

            if (mem_data_ok && (count == '0))
                arb_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed and randomized checks of sram_port_arbiter against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int MAXO = 4;
    localparam int SLIM = 8;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [3:0]  inst_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [3:0]  data_wstrb = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;
    logic        arb_err;

    sram_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
        .aclk(aclk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Reference model: owners of outstanding transactions in issue order
    bit q[$];
    bit locked = 0, lock_own = 0, err_m = 0;
    int starve = 0;
    bit m_sel, m_req, m_hs, m_pop, m_err, m_head;
    bit inst_pend = 0, data_pend = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        locked = 0; lock_own = 0; err_m = 0; starve = 0;
    endtask

    // Evaluate model at the negedge and compare all outputs
    task automatic half();
        logic [70:0] exp_fields;
        @(negedge aclk);
        if (locked)                            m_sel = lock_own;
        else if (inst_req && starve == SLIM)   m_sel = 1'b0;
        else                                   m_sel = data_req;
        m_req  = (m_sel ? data_req : inst_req) && (q.size() < MAXO);
        m_hs   = m_req && mem_addr_ok;
        m_err  = mem_data_ok && (q.size() == 0);
        m_pop  = mem_data_ok && (q.size() != 0);
        m_head = m_pop ? q[0] : 1'b0;
        exp_fields = m_sel ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                           : {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
        chk("mem_req", 80'(mem_req), 80'(m_req));
        if (m_req)
            chk("mem_fields", 80'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 80'(exp_fields));
        chk("inst_addr_ok", 80'(inst_addr_ok), 80'(m_hs && !m_sel));
        chk("data_addr_ok", 80'(data_addr_ok), 80'(m_hs && m_sel));
        chk("inst_data_ok", 80'(inst_data_ok), 80'(m_pop && !m_head));
        chk("data_data_ok", 80'(data_data_ok), 80'(m_pop && m_head));
        chk("rdata", 80'({inst_rdata, data_rdata}), 80'({mem_rdata, mem_rdata}));
        chk("arb_err", 80'(arb_err), 80'(err_m));
    endtask

    task automatic step_edge();
        @(posedge aclk);
        if (m_pop) void'(q.pop_front());
        if (m_hs) q.push_back(m_sel);
        if (m_err) err_m = 1;
        if (m_hs) locked = 0;
        else if (m_req && !locked) begin locked = 1; lock_own = m_sel; end
        if (!inst_req || (m_hs && !m_sel)) starve = 0;
        else if (m_hs && m_sel && starve < SLIM) starve++;
        #1;
    endtask

    task automatic cyc();
        half();
        step_edge();
    endtask

    task automatic idle_in();
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic drain();
        idle_in();
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            mem_data_ok = 1; mem_rdata = $urandom;
            cyc();
        end
        mem_data_ok = 0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_mem_req", 80'(mem_req), 80'(0));
        chk("rst_addr_ok", 80'({inst_addr_ok, data_addr_ok}), 80'(0));
        chk("rst_arb_err", 80'(arb_err), 80'(0));
        @(posedge aclk); #1; reset = 0;

        // Single fetch: address then data
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        half();
        chk("t1_inst_addr_ok", 80'(inst_addr_ok), 80'(1));
        chk("t1_mem_addr", 80'(mem_addr), 80'(32'h1c000000));
        step_edge();
        idle_in(); mem_data_ok = 1; mem_rdata = 32'h02800000;
        half();
        chk("t1_inst_data_ok", 80'(inst_data_ok), 80'(1));
        chk("t1_inst_rdata", 80'(inst_rdata), 80'(32'h02800000));
        step_edge();
        mem_data_ok = 0;

        // Data wins a tie, returns routed D then I
        inst_req = 1; inst_addr = 32'h1c000004; data_req = 1; data_addr = 32'h80001000; mem_addr_ok = 1;
        half(); chk("t2_data_first", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b10)); step_edge();
        data_req = 0;
        half(); chk("t2_inst_next", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b01)); step_edge();
        idle_in(); mem_data_ok = 1;
        half(); chk("t2_ret_d", 80'({data_data_ok, inst_data_ok}), 80'(2'b10)); step_edge();
        half(); chk("t2_ret_i", 80'({data_data_ok, inst_data_ok}), 80'(2'b01)); step_edge();
        idle_in();

        // Lock holds data while addr_ok stalls
        data_req = 1; data_addr = 32'h80002000; mem_addr_ok = 0;
        cyc();
        inst_req = 1; inst_addr = 32'h1c000008;
        half(); chk("t3_lock_addr1", 80'(mem_addr), 80'(32'h80002000)); step_edge();
        half(); chk("t3_lock_addr2", 80'(mem_addr), 80'(32'h80002000)); step_edge();
        mem_addr_ok = 1;
        half(); chk("t3_grant_data", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b10)); step_edge();
        data_req = 0;
        half(); chk("t3_grant_inst", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b01)); step_edge();
        drain();

        // Fill the owner FIFO, then release one slot
        data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < MAXO; i++) begin
            data_addr = 32'h80003000 + 32'(i * 4);
            cyc();
        end
        data_addr = 32'h80003100;
        half(); chk("t4_full_blocks", 80'(mem_req), 80'(0)); step_edge();
        mem_data_ok = 1;
        half(); chk("t4_full_pop", 80'({mem_req, data_data_ok}), 80'(2'b01)); step_edge();
        mem_data_ok = 0;
        half(); chk("t4_refill", 80'({mem_req, data_addr_ok}), 80'(2'b11)); step_edge();
        data_addr = 32'h80003104;
        half(); chk("t4_full_again", 80'(mem_req), 80'(0)); step_edge();
        drain();

        // Starvation: 8 data grants, then fetch, then data again
        inst_req = 1; inst_addr = 32'h1c000010; data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < SLIM + 2; i++) begin
            data_addr = 32'h80004000 + 32'(i * 4);
            mem_data_ok = (q.size() != 0);
            half();
            if (i < SLIM)       chk("t5_data_grant", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b10));
            else if (i == SLIM) chk("t5_inst_forced", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b01));
            else                chk("t5_data_after", 80'({data_addr_ok, inst_addr_ok}), 80'(2'b10));
            step_edge();
            if (i == SLIM) inst_addr = 32'h1c000014;
        end
        drain();

        // Spurious return sets a sticky error
        mem_data_ok = 1;
        half(); chk("t6_no_data_ok", 80'({data_data_ok, inst_data_ok}), 80'(0)); step_edge();
        mem_data_ok = 0;
        half(); chk("t6_err_set", 80'(arb_err), 80'(1)); step_edge();
        cyc(); cyc();
        chk("t6_err_sticky", 80'(arb_err), 80'(1));

        // Asynchronous reset with three outstanding
        data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            data_addr = 32'h80005000 + 32'(i * 4);
            cyc();
        end
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        half();
        chk("t7_pre_data_ok", 80'(data_data_ok), 80'(1));
        reset = 1; #1;
        model_clear();
        chk("t7_rst_data_ok", 80'({data_data_ok, inst_data_ok}), 80'(0));
        chk("t7_rst_err", 80'(arb_err), 80'(0));
        chk("t7_rst_mem_req", 80'(mem_req), 80'(0));
        @(posedge aclk); #1; reset = 0;
        half(); chk("t7_late_ret", 80'(data_data_ok), 80'(0)); step_edge();
        mem_data_ok = 0;
        half(); chk("t7_late_err", 80'(arb_err), 80'(1)); step_edge();

        reset = 1; #1; model_clear();
        @(posedge aclk); #1; reset = 0;

        // Randomized traffic with protocol-compliant requesters
        for (int c = 0; c < 3000; c++) begin
            if (!inst_pend && ($urandom % 2 == 0)) begin
                inst_pend = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom);
                inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_pend && ($urandom % 2 == 0)) begin
                data_pend = 1; data_wr = 1'($urandom); data_size = 2'($urandom);
                data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req    = inst_pend;
            data_req    = data_pend;
            mem_addr_ok = ($urandom % 4) != 0;
            mem_data_ok = (q.size() != 0) && (($urandom % 3) != 0);
            mem_rdata   = $urandom;
            cyc();
            if (m_hs) begin
                if (m_sel) data_pend = 0;
                else       inst_pend = 0;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stage). Each requester uses the req/addr_ok/data_ok handshake. The arbiter grants at most one address handshake per cycle and tracks the owner of every outstanding transaction in an in-order owner FIFO, so each data_ok/rdata is routed back to the requester that issued it. Data requests win by default. A starvation counter guarantees forward progress for fetch. The block sits between the core stages and the sram-to-AXI bridge.

## Interface
- MAX_OUTSTANDING, 4: maximum accepted-but-unreturned transactions; owner FIFO depth; power of two, ≥2
- STARVE_LIMIT, 8: consecutive data grants allowed while inst_req is pending before inst is forced ahead
- aclk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- inst_req / inst_wr  in  1 / 1  fetch request, write flag
- inst_size  in  2  transfer size
- inst_wstrb  in  4  byte strobes
- inst_addr / inst_wdata  in  32 / 32  address, write data
- inst_addr_ok / inst_data_ok  out  1 / 1  fetch address accepted / fetch data returned
- inst_rdata  out  32  fetch read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  same widths as the inst_* inputs  data requester inputs
- data_addr_ok, data_data_ok, data_rdata  out  1, 1, 32  data requester outputs
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  same widths as the inst_* inputs  downstream request
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream handshakes
- mem_rdata  in  32  downstream read data
- arb_err  out  1  sticky; set by mem_data_ok while the owner FIFO is empty

## Operation
- Selection (sel: 1 = data, 0 = inst):
  - If lock_valid is set, sel = lock_owner.
  - Otherwise, if inst_req is high and starve_cnt == STARVE_LIMIT, sel = inst.
  - Otherwise, sel = data when data_req is high.
  - Otherwise, sel = inst.
- mem_req = (the selected requester's req) & ~full. All mem_* request fields mux from the selected requester.
- Address handshake:
  - mem_req & mem_addr_ok is a handshake.
  - The selected requester's addr_ok = mem_addr_ok & mem_req. The other requester's addr_ok = 0.
  - Each handshake pushes sel into the owner FIFO.
- Lock:
  - Set when mem_req & ~mem_addr_ok & ~lock_valid. lock_owner = sel.
  - Cleared on handshake.
  - Prevents switching requester while a request waits for addr_ok. Requesters hold req stable until addr_ok.
  - While locked the FIFO cannot be full, because count only decreases without a handshake. The full gate therefore never drops a locked request.
- Return path:
  - On mem_data_ok with the FIFO non-empty, pop the head. Assert the head owner's data_ok the same cycle. Drive both rdata outputs from mem_rdata.
  - The non-owner's data_ok = 0.
- Owner FIFO:
  - count is 0..MAX_OUTSTANDING. full = (count == MAX_OUTSTANDING).
  - Read and write pointers are log2(MAX_OUTSTANDING) bits and wrap naturally.
  - A simultaneous push and pop leaves count unchanged. Push is allowed at full only if a pop occurs in the same cycle; mem_req still gates on full, so in practice it does not happen.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 on a data handshake while inst_req is high, saturating at STARVE_LIMIT.
  - Cleared on an inst handshake or whenever inst_req is low.
- arb_err: mem_data_ok with count == 0 sets the flag. No pop and no data_ok are generated. Only reset clears it.

## Timing
- Reset values:
  - count, pointers, lock_valid, lock_owner, starve_cnt and arb_err are 0.
  - All addr_ok, data_ok and mem_req outputs are 0. rdata follows mem_rdata.
- Zero added latency. req→mem_req, mem_addr_ok→addr_ok and mem_data_ok→data_ok are combinational, same cycle.
- State changes (push, pop, lock, counter) take effect on the following edge.
- Reset asserted mid-transaction discards all outstanding ownership. Returns arriving after reset are protocol errors and set arb_err.
- Throughput: one handshake per cycle when mem_addr_ok is high and the FIFO is not full.

## Test plan
- Both requesters idle, then inst_req=1 at addr 0x1c000000 with mem_addr_ok=1 → inst_addr_ok=1 the same cycle and count=1. mem_data_ok with rdata 0x02800000 → inst_data_ok=1 and count=0.
- inst_req and data_req high together, mem_addr_ok=1 → data granted first. inst granted the next cycle once data_req drops. Returns in order D,I → data_data_ok then inst_data_ok.
- data_req raised, mem_addr_ok=0 for 3 cycles, inst_req raised in cycle 1 → mem_addr stays the data address (lock held). The grant goes to data on the cycle mem_addr_ok=1, and only then may inst win.
- Issue 4 requests with no data_ok → count=4 and mem_req=0 despite a pending req. One mem_data_ok arrives in the same cycle as a pending req → mem_req=1 the next cycle and count stays 4 after the next handshake.
- data_req held continuously, inst_req high, STARVE_LIMIT=8 → after 8 data handshakes the 9th grant goes to inst, then starve_cnt returns to 0.
- mem_data_ok pulsed with count=0 → no data_ok asserted and arb_err=1 persists. Async reset mid-burst with count=3 → all state reads 0 immediately, without waiting for a clock edge.
